// File: rtl/demux4_router_if.sv
// demux4_router producer/consumer bundle.
// The router takes the slave side; producer and consumers the master side.
interface demux4_router_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] In;
    logic [1:0]       Sel;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Out0;
    logic [WIDTH-1:0] Out1;
    logic [WIDTH-1:0] Out2;
    logic [WIDTH-1:0] Out3;
    logic [3:0]       OutValid;
    logic [3:0]       OutReady;

    modport master (
        output In,
        output Sel,
        output InValid,
        output OutReady,
        input  InReady,
        input  Out0,
        input  Out1,
        input  Out2,
        input  Out3,
        input  OutValid
    );

    modport slave (
        input  In,
        input  Sel,
        input  InValid,
        input  OutReady,
        output InReady,
        output Out0,
        output Out1,
        output Out2,
        output Out3,
        output OutValid
    );
endinterface

// File: rtl/demux4_router.sv
// Buffered 1-to-4 word router, one 2-entry FIFO per destination.
// Optional DEMUX4_ROUTER_STATS_EN adds saturating per-channel push counters.
module demux4_router #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    demux4_router_if.slave bus
`ifdef DEMUX4_ROUTER_STATS_EN
    ,
    output logic [15:0] Stat0,
    output logic [15:0] Stat1,
    output logic [15:0] Stat2,
    output logic [15:0] Stat3
`endif
);

    logic [WIDTH-1:0] data_q [4][2];
    logic [WIDTH-1:0] data_d [4][2];
    logic             wptr_q [4];
    logic             wptr_d [4];
    logic             rptr_q [4];
    logic             rptr_d [4];
    logic [1:0]       cnt_q  [4];
    logic [1:0]       cnt_d  [4];

    logic [3:0] push;
    logic [3:0] pop;
    logic       in_ready;

    // Ready looks only at the selected channel's fill level.
    always_comb begin
        in_ready = (cnt_q[bus.Sel] != 2'd2);
        for (int n = 0; n < 4; n++) begin
            push[n] = bus.InValid && in_ready && (bus.Sel == 2'(n));
            pop[n]  = (cnt_q[n] != 2'd0) && bus.OutReady[n];
        end
    end

    always_comb begin
        data_d = data_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int n = 0; n < 4; n++) begin
            if (push[n]) begin
                data_d[n][wptr_q[n]] = bus.In;
                wptr_d[n] = ~wptr_q[n];
            end
            if (pop[n]) begin
                rptr_d[n] = ~rptr_q[n];
            end
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + 2'd1;
                2'b01:   cnt_d[n] = cnt_q[n] - 2'd1;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                data_q[n][0] <= '0;
                data_q[n][1] <= '0;
                wptr_q[n]    <= 1'b0;
                rptr_q[n]    <= 1'b0;
                cnt_q[n]     <= 2'd0;
            end
        end else begin
            data_q <= data_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.InReady = in_ready;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            bus.OutValid[n] = (cnt_q[n] != 2'd0);
        end
    end

    assign bus.Out0 = data_q[0][rptr_q[0]];
    assign bus.Out1 = data_q[1][rptr_q[1]];
    assign bus.Out2 = data_q[2][rptr_q[2]];
    assign bus.Out3 = data_q[3][rptr_q[3]];

`ifdef DEMUX4_ROUTER_STATS_EN
    logic [15:0] stat_q [4];
    logic [15:0] stat_d [4];

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            stat_d[n] = stat_q[n];
            if (push[n] && (stat_q[n] != 16'hFFFF)) begin
                stat_d[n] = stat_q[n] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                stat_q[n] <= 16'd0;
            end
        end else begin
            stat_q <= stat_d;
        end
    end

    assign Stat0 = stat_q[0];
    assign Stat1 = stat_q[1];
    assign Stat2 = stat_q[2];
    assign Stat3 = stat_q[3];
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Randomized bench for demux4_router against a queue-based reference.
// With DEMUX4_ROUTER_STATS_EN it also checks the push counters and saturation.
module tb_demux4_router;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux4_router_if #(.WIDTH(32)) bus ();

`ifdef DEMUX4_ROUTER_STATS_EN
    logic [15:0] st0, st1, st2, st3;
`endif

    demux4_router #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DEMUX4_ROUTER_STATS_EN
        ,
        .Stat0 (st0),
        .Stat1 (st1),
        .Stat2 (st2),
        .Stat3 (st3)
`endif
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] mq [4][$];
    bit          clean [4];
    int unsigned mstat [4];
    bit          known = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] outn(input int n);
        case (n)
            0:       return bus.Out0;
            1:       return bus.Out1;
            2:       return bus.Out2;
            default: return bus.Out3;
        endcase
    endfunction

`ifdef DEMUX4_ROUTER_STATS_EN
    function automatic logic [15:0] statn(input int n);
        case (n)
            0:       return st0;
            1:       return st1;
            2:       return st2;
            default: return st3;
        endcase
    endfunction
`endif

    task automatic check_outs();
        logic [3:0] ev;
        for (int n = 0; n < 4; n++) ev[n] = (mq[n].size() > 0);
        check("out_valid", 64'(bus.OutValid), 64'(ev));
        for (int n = 0; n < 4; n++) begin
            if (mq[n].size() > 0)
                check($sformatf("out%0d", n), 64'(outn(n)), 64'(mq[n][0]));
            else if (clean[n])
                check($sformatf("out%0d_zero", n), 64'(outn(n)), 64'd0);
            check($sformatf("cnt%0d_range", n),
                  64'(dut.cnt_q[n] <= 2'd2), 64'd1);
`ifdef DEMUX4_ROUTER_STATS_EN
            check($sformatf("stat%0d", n), 64'(statn(n)), 64'(mstat[n]));
`endif
        end
    endtask

    // One clock: check ready, predict the edge, then check outputs.
    task automatic cyc();
        bit          acc;
        bit [3:0]    pp;
        logic [1:0]  s;
        logic [31:0] d;
        s = bus.Sel;
        d = bus.In;
        if (known)
            check("in_ready", 64'(bus.InReady), 64'(mq[s].size() < 2));
        acc = bus.InValid && (mq[s].size() < 2);
        for (int n = 0; n < 4; n++)
            pp[n] = bus.OutReady[n] && (mq[n].size() > 0);
        @(posedge clk);
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                mq[n].delete();
                clean[n] = 1'b1;
                mstat[n] = 0;
            end
            known = 1'b1;
        end else if (known) begin
            for (int n = 0; n < 4; n++)
                if (pp[n]) void'(mq[n].pop_front());
            if (acc) begin
                mq[s].push_back(d);
                clean[s] = 1'b0;
                if (mstat[s] < 65535) mstat[s]++;
            end
        end
        @(negedge clk);
        if (known) check_outs();
    endtask

    task automatic drv(input bit v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
        bus.InValid  = v;
        bus.Sel      = s;
        bus.In       = d;
        bus.OutReady = r;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.InValid  = 1'b0;
        bus.Sel      = 2'd0;
        bus.In       = '0;
        bus.OutReady = 4'b0;
        for (int n = 0; n < 4; n++) begin
            clean[n] = 1'b1;
            mstat[n] = 0;
        end
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) drv(1'b0, 2'(s), 32'd0, 4'b0);

        // single route
        drv(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        drv(1'b0, 2'd2, 32'h0, 4'b0000);
        drv(1'b0, 2'd0, 32'h0, 4'b0100);
        drv(1'b0, 2'd0, 32'h0, 4'b0000);

        // full channel, neighbours unaffected, no pass-through when full
        drv(1'b1, 2'd1, 32'hA1, 4'b0000);
        drv(1'b1, 2'd1, 32'hA2, 4'b0000);
        drv(1'b1, 2'd1, 32'hA3, 4'b0000);
        drv(1'b1, 2'd3, 32'hB1, 4'b0000);
        drv(1'b1, 2'd1, 32'hA4, 4'b0010);
        drv(1'b0, 2'd1, 32'h0, 4'b0010);
        drv(1'b0, 2'd1, 32'h0, 4'b1010);
        drv(1'b0, 2'd1, 32'h0, 4'b1010);

        // simultaneous push/pop and sustained streaming
        drv(1'b1, 2'd0, 32'h1111, 4'b0000);
        drv(1'b1, 2'd0, 32'h2222, 4'b0001);
        for (int i = 0; i < 8; i++)
            drv(1'b1, 2'd0, 32'h100 + 32'(i), 4'b0001);
        drv(1'b0, 2'd0, 32'h0, 4'b0001);
        drv(1'b0, 2'd0, 32'h0, 4'b0001);

        // reset mid-stream
        drv(1'b1, 2'd0, 32'hC0, 4'b0);
        drv(1'b1, 2'd0, 32'hC1, 4'b0);
        drv(1'b1, 2'd2, 32'hE0, 4'b0);
        drv(1'b1, 2'd2, 32'hE1, 4'b0);
        rst = 1'b1;
        drv(1'b1, 2'd2, 32'hE2, 4'b1111);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) drv(1'b0, 2'(s), 32'd0, 4'b1111);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drv(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                $urandom, 4'($urandom));
        end
        rst = 1'b0;

`ifdef DEMUX4_ROUTER_STATS_EN
        rst = 1'b1;
        drv(1'b0, 2'd0, 32'h0, 4'b0);
        rst = 1'b0;
        for (int i = 0; i < 65537; i++)
            drv(1'b1, 2'd3, 32'(i), 4'b1000);
        drv(1'b0, 2'd3, 32'h0, 4'b1000);
        check("stat3_sat", 64'(st3), 64'hFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/demux4_router.md
# demux4_router

Buffered 1-to-4 word router: the distributing counterpart to the team's 4-input select mux. A single producer presents a WIDTH-bit word with a 2-bit destination `Sel`. The block steers each accepted word into one of four independent 2-entry FIFOs, and each FIFO drains on its own valid/ready channel. It sits where one result stream fans out to several consumers, such as the write-back source feeding peripheral or register-file ports, and isolates the producer from per-consumer stalls.

## Interface
- WIDTH, 32, data word width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- In  input  WIDTH  input data word.
- Sel  input  2  destination channel for `In` (0..3).
- InValid  input  1  producer has a word on `In`/`Sel`.
- InReady  output  1  word on `In` is accepted this cycle when `InValid` is also high.
- Out0..Out3  output  WIDTH each  head-of-FIFO data for channel n.
- OutValid  output  4  bit n high: `Outn` holds a valid word.
- OutReady  input  4  bit n high: consumer n takes `Outn` this cycle.
- Stat0..Stat3  output  16 each  accepted-word counters; present only with DEMUX4_ROUTER_STATS_EN.

## Operation
- Four identical channels, each with a 2-entry FIFO: two data registers, a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2).
- `InReady` is combinational: `InReady = (count[Sel] != 2)`.
  - It depends on `Sel` and the full state only.
  - It never depends on `InValid` or `OutReady`, so there is no combinational path from consumers to the producer.
- Push: `InValid & InReady` at a rising edge writes `In` to `fifo[Sel][wptr]`, advances `wptr`, and increments count.
- Pop on channel n: `OutValid[n] & OutReady[n]` at a rising edge advances `rptr[n]` and decrements count.
- `OutValid[n] = (count[n] != 0)`. `Outn` shows `fifo[n][rptr[n]]` and is registered data, not a combinational bypass.
- Simultaneous push and pop on the same channel: count is unchanged, both pointers advance, and ordering is preserved.
- Push to a full channel: not possible, because `InReady` is low. This holds even if that channel pops in the same cycle; no pass-through when full.
- `OutReady[n]` while empty: ignored; count, pointers and counters are unchanged.
- Per-channel order is strict FIFO. There is no ordering guarantee across channels.
- Pointers wrap 1 -> 0.
- Count never exceeds 2 or goes below 0. Any other value is a design error, checked by an assertion in the bench.
- Channels never block one another: a full channel 2 does not affect `InReady` when `Sel` is 0, 1 or 3.

## Timing
- Latency: a word accepted at edge k is visible on `Outn` with `OutValid[n]=1` after edge k, i.e. in cycle k+1. Minimum in-to-out latency is one cycle.
- Throughput: one push per cycle overall and one pop per cycle per channel.
- A channel with a consumer holding `OutReady` high sustains one word per cycle.
- Reset (`rst` high at an edge), for all channels:
  - count=0, pointers=0, `OutValid`=4'b0000.
  - FIFO data registers and `Out0..Out3` = 0.
  - Stat counters = 0.
- While `rst` is high, `InReady` still evaluates normally, but nothing is pushed or popped at that edge; reset wins over any handshake.
- Reset mid-stream discards all buffered words.
- `Sel` and `In` are sampled only at the accepting edge. Changes while `InValid` is low or `InReady` is low have no effect.

## Configuration
- Macro: DEMUX4_ROUTER_STATS_EN.
- Defined:
  - Ports `Stat0..Stat3` exist.
  - `Statn` increments by 1 at each accepted push to channel n and saturates at 16'hFFFF.
  - Cleared only by `rst`.
  - Values are registered and update in the cycle after the push.
- Not defined: the four ports and counter registers are absent. All other behaviour is identical, cycle for cycle.

## Test plan
- Reset then idle:
  - Assert `rst` for 2 cycles -> `OutValid`=0000, `Out0..3`=0, `InReady`=1 for every `Sel`.
  - With STATS, all `Statn`=0.
- Single route:
  - Push `In`=32'hDEADBEEF, `Sel`=2, `OutReady`=0 -> in the next cycle `OutValid`=0100 and `Out2`=DEADBEEF.
  - The word holds until `OutReady[2]` is pulsed, then `OutValid`=0000.
- Full channel:
  - `OutReady`=0, push A1, A2 to `Sel`=1 -> `InReady`=0 while `Sel`=1, and `InReady`=1 while `Sel`=3.
  - Push B1 to channel 3 -> `OutValid`=1010.
  - Pop channel 1 -> `Out1` shows A1 then A2, in order.
- Simultaneous push/pop:
  - Channel 0 holds 1 word X, `OutReady[0]`=1, push Y to `Sel`=0 in the same cycle -> count stays 1 and `Out0`=Y next cycle.
  - Sustain 8 pushes with continuous pop -> 8 words out, one per cycle, in order.
- Reset mid-stream: channels 0 and 2 each hold 2 words, then assert `rst` -> next cycle `OutValid`=0000 and all `InReady` high. The old words never reappear.
- Stats saturation (STATS build): force `Stat3` to 16'hFFFE, push 3 words to channel 3 with `OutReady[3]`=1 -> `Stat3` reads FFFF and stays there.
